// File: rtl/ula_ctrl_idex_pkg.sv
// Shared ALU-control types, MIPS opcode/funct constants and immediate extenders
// for the ID/EX stage feeding the 32-slice ALU array.
package ula_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_NOR  = 3'b011,
    OP_RSVD = 3'b100,
    OP_XOR  = 3'b101,
    OP_SUB  = 3'b110,
    OP_SLT  = 3'b111
  } ula_op_t;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // Extenders produce the widest supported datapath; callers truncate to WIDTH.
  localparam int EXT_W = 64;

  function automatic logic [EXT_W-1:0] sign_ext16(input logic [15:0] imm);
    return {{(EXT_W-16){imm[15]}}, imm};
  endfunction

  function automatic logic [EXT_W-1:0] zero_ext16(input logic [15:0] imm);
    return {{(EXT_W-16){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/ula_ctrl_idex_decoder.sv
// Combinational opcode/funct decoder producing the ALU slice operation,
// operand-B source, immediate extension kind, overflow-trap enable and illegal flag.
module ula_decoder
  import ula_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ula_op_t    op,
  output logic       use_imm,
  output logic       zext,
  output logic       ovf_en,
  output logic       illegal
);

  always_comb begin
    op      = OP_AND;
    use_imm = 1'b0;
    zext    = 1'b0;
    ovf_en  = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_ADD:  begin op = OP_ADD; ovf_en = 1'b1; end
          FN_ADDU: op = OP_ADD;
          FN_SUB:  begin op = OP_SUB; ovf_en = 1'b1; end
          FN_SUBU: op = OP_SUB;
          FN_AND:  op = OP_AND;
          FN_OR:   op = OP_OR;
          FN_XOR:  op = OP_XOR;
          FN_NOR:  op = OP_NOR;
          FN_SLT:  op = OP_SLT;
          default: illegal = 1'b1;
        endcase
      end
      OPC_ADDI:  begin op = OP_ADD; use_imm = 1'b1; ovf_en = 1'b1; end
      OPC_ADDIU: begin op = OP_ADD; use_imm = 1'b1; end
      OPC_SLTI:  begin op = OP_SLT; use_imm = 1'b1; end
      OPC_ANDI:  begin op = OP_AND; use_imm = 1'b1; zext = 1'b1; end
      OPC_ORI:   begin op = OP_OR;  use_imm = 1'b1; zext = 1'b1; end
      OPC_XORI:  begin op = OP_XOR; use_imm = 1'b1; zext = 1'b1; end
      OPC_LW,
      OPC_SW:    begin op = OP_ADD; use_imm = 1'b1; end
      OPC_BEQ,
      OPC_BNE:   op = OP_SUB;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ula_ctrl_idex.sv
// ID/EX stage: decodes ALU controls, selects operand B and registers the op
// behind a valid/ready handshake with stall and flush.
module ula_ctrl_idex
  import ula_pkg::*;
#(
  parameter int         WIDTH      = 32,
  parameter logic [2:0] RESET_CTRL = 3'b000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [15:0]      imm16,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  output logic [2:0]       ULAcontrole,
  output logic             addsub,
  output logic             cin0,
  output logic             is_slt,
  output logic             ovf_en,
  output logic             illegal
);

  ula_op_t          dec_op;
  logic             dec_use_imm, dec_zext, dec_ovf_en, dec_illegal;
  logic [WIDTH-1:0] imm_ext;
  logic             load;

  logic             valid_q, valid_d;
  logic             illegal_q, illegal_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic             addsub_q, addsub_d;
  logic             is_slt_q, is_slt_d;
  logic             ovf_en_q, ovf_en_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  ula_decoder u_dec (
    .opcode  (opcode),
    .funct   (funct),
    .op      (dec_op),
    .use_imm (dec_use_imm),
    .zext    (dec_zext),
    .ovf_en  (dec_ovf_en),
    .illegal (dec_illegal)
  );

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready;
  assign imm_ext  = dec_zext ? WIDTH'(zero_ext16(imm16)) : WIDTH'(sign_ext16(imm16));

  // Decoder results only reach the flops on a load, so garbage on idle inputs stays out.
  always_comb begin
    valid_d   = valid_q;
    illegal_d = illegal_q;
    ctrl_d    = ctrl_q;
    addsub_d  = addsub_q;
    is_slt_d  = is_slt_q;
    ovf_en_d  = ovf_en_q;
    a_d       = a_q;
    b_d       = b_q;
    if (flush) begin
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else if (load) begin
      valid_d   = 1'b1;
      illegal_d = dec_illegal;
      a_d       = rs_data;
      b_d       = dec_use_imm ? imm_ext : rt_data;
      if (dec_illegal) begin
        ctrl_d   = RESET_CTRL;
        addsub_d = 1'b0;
        is_slt_d = 1'b0;
        ovf_en_d = 1'b0;
      end else begin
        ctrl_d   = dec_op;
        addsub_d = (dec_op == OP_SUB) || (dec_op == OP_SLT);
        is_slt_d = (dec_op == OP_SLT);
        ovf_en_d = dec_ovf_en;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      ctrl_q    <= RESET_CTRL;
      addsub_q  <= 1'b0;
      is_slt_q  <= 1'b0;
      ovf_en_q  <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      ctrl_q    <= ctrl_d;
      addsub_q  <= addsub_d;
      is_slt_q  <= is_slt_d;
      ovf_en_q  <= ovf_en_d;
    end
  end

  // Operands are qualified by out_valid, so they carry no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign out_valid   = valid_q;
  assign illegal     = illegal_q;
  assign ULAcontrole = ctrl_q;
  assign addsub      = addsub_q;
  assign cin0        = addsub_q;
  assign is_slt      = is_slt_q;
  assign ovf_en      = ovf_en_q;
  assign ula_a       = a_q;
  assign ula_b       = b_q;

endmodule

// File: tb/tb_ula_ctrl_idex.sv
// Directed self-checking bench for ula_ctrl_idex: reset, decode, immediates,
// stall, flush, back-to-back throughput and illegal-instruction bubbles.
module tb_ula_ctrl_idex;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [15:0] imm16;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ula_a;
  logic [31:0] ula_b;
  logic [2:0]  ULAcontrole;
  logic        addsub;
  logic        cin0;
  logic        is_slt;
  logic        ovf_en;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  ula_ctrl_idex #(.WIDTH(32), .RESET_CTRL(3'b000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opcode      (opcode),
    .funct       (funct),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .imm16       (imm16),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ula_a       (ula_a),
    .ula_b       (ula_b),
    .ULAcontrole (ULAcontrole),
    .addsub      (addsub),
    .cin0        (cin0),
    .is_slt      (is_slt),
    .ovf_en      (ovf_en),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [5:0] opc, input logic [5:0] fn, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [15:0] imm);
    in_valid = 1'b1;
    opcode   = opc;
    funct    = fn;
    rs_data  = rs;
    rt_data  = rt;
    imm16    = imm;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    present(6'h00, 6'h20, 32'd1, 32'd2, 16'h0000);
    #2;
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_ctrl", ULAcontrole, 3'b000);
    check("rst_addsub", addsub, 0);
    check("rst_cin0", cin0, 0);
    check("rst_is_slt", is_slt, 0);
    check("rst_ovf_en", ovf_en, 0);
    check("rst_illegal", illegal, 0);

    // sub accepted on the first cycle out of reset
    rst_n = 1'b1;
    present(6'h00, 6'h22, 32'd5, 32'd3, 16'h0000);
    #1;
    check("sub_in_ready", in_ready, 1);
    step();
    check("sub_valid", out_valid, 1);
    check("sub_ctrl", ULAcontrole, 3'b110);
    check("sub_addsub", addsub, 1);
    check("sub_cin0", cin0, 1);
    check("sub_a", ula_a, 32'd5);
    check("sub_b", ula_b, 32'd3);
    check("sub_ovf_en", ovf_en, 1);
    check("sub_is_slt", is_slt, 0);

    present(6'h0A, 6'h3F, 32'd7, 32'd99, 16'hFFFF);
    step();
    check("slti_b", ula_b, 32'hFFFF_FFFF);
    check("slti_ctrl", ULAcontrole, 3'b111);
    check("slti_is_slt", is_slt, 1);
    check("slti_addsub", addsub, 1);
    check("slti_ovf_en", ovf_en, 0);

    present(6'h0C, 6'h00, 32'd7, 32'd99, 16'hFFFF);
    step();
    check("andi_b", ula_b, 32'h0000_FFFF);
    check("andi_ctrl", ULAcontrole, 3'b000);
    check("andi_addsub", addsub, 0);

    present(6'h08, 6'h00, 32'd10, 32'd0, 16'h8001);
    step();
    check("addi_b", ula_b, 32'hFFFF_8001);
    check("addi_ctrl", ULAcontrole, 3'b010);
    check("addi_ovf_en", ovf_en, 1);

    present(6'h23, 6'h00, 32'h100, 32'd0, 16'h8000);
    step();
    check("lw_b", ula_b, 32'hFFFF_8000);
    check("lw_ovf_en", ovf_en, 0);

    present(6'h04, 6'h00, 32'h11, 32'h55, 16'h1234);
    step();
    check("beq_ctrl", ULAcontrole, 3'b110);
    check("beq_b", ula_b, 32'h55);

    // stall: or held while out_ready is low, add waits upstream
    present(6'h00, 6'h25, 32'd1, 32'd2, 16'h0000);
    step();
    check("or_ctrl", ULAcontrole, 3'b001);
    present(6'h00, 6'h20, 32'd9, 32'd4, 16'h0000);
    out_ready = 1'b0;
    #1;
    check("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", out_valid, 1);
      check("stall_ctrl", ULAcontrole, 3'b001);
      check("stall_b", ula_b, 32'd2);
      check("stall_in_ready_hold", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", in_ready, 1);
    step();
    check("add_after_stall_ctrl", ULAcontrole, 3'b010);
    check("add_after_stall_a", ula_a, 32'd9);
    check("add_after_stall_b", ula_b, 32'd4);

    // flush wins over a simultaneous load
    present(6'h00, 6'h26, 32'd3, 32'd3, 16'h0000);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_illegal", illegal, 0);

    present(6'h00, 6'h20, 32'd1, 32'd1, 16'h0000);
    step();
    check("b2b_add_valid", out_valid, 1);
    check("b2b_add_ctrl", ULAcontrole, 3'b010);
    present(6'h00, 6'h27, 32'd1, 32'd1, 16'h0000);
    step();
    check("b2b_nor_valid", out_valid, 1);
    check("b2b_nor_ctrl", ULAcontrole, 3'b011);
    present(6'h00, 6'h2A, 32'd1, 32'd1, 16'h0000);
    step();
    check("b2b_slt_valid", out_valid, 1);
    check("b2b_slt_ctrl", ULAcontrole, 3'b111);

    // drain with X on the idle decode inputs: controls hold their last value
    in_valid = 1'b0;
    opcode   = 6'bxxxxxx;
    funct    = 6'bxxxxxx;
    step();
    check("drain_valid", out_valid, 0);
    check("drain_ctrl_hold", ULAcontrole, 3'b111);
    check("drain_addsub_hold", addsub, 1);
    check("drain_illegal", illegal, 0);

    present(6'h3F, 6'h20, 32'd1, 32'd1, 16'h0000);
    step();
    check("ill_opc_valid", out_valid, 1);
    check("ill_opc_flag", illegal, 1);
    check("ill_opc_ctrl", ULAcontrole, 3'b000);
    check("ill_opc_addsub", addsub, 0);
    check("ill_opc_ovf_en", ovf_en, 0);

    present(6'h00, 6'h00, 32'd1, 32'd1, 16'h0000);
    step();
    check("ill_fn_flag", illegal, 1);

    present(6'h0E, 6'h00, 32'd1, 32'd1, 16'hABCD);
    step();
    check("xori_illegal_clr", illegal, 0);
    check("xori_ctrl", ULAcontrole, 3'b101);
    check("xori_b", ula_b, 32'h0000_ABCD);

    // reset during a stall discards the held op
    present(6'h00, 6'h25, 32'd1, 32'd2, 16'h0000);
    step();
    out_ready = 1'b0;
    rst_n     = 1'b0;
    step();
    check("rst_stall_valid", out_valid, 0);
    check("rst_stall_ctrl", ULAcontrole, 3'b000);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
